reg_writeback_ctrl: RTL

Write-side master for the 32x32 register file. It accepts results from the single-cycle ALU path and the multi-cycle load path, formats load data, and arbitrates both onto the single write port (RegWrite/Rd/Write_data). It also keeps a per-register pending-write scoreboard that throttles instruction issue against RAW/WAW hazards.

---
 rtl/reg_writeback_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reg_writeback_ctrl.sv
// Write-side master for a 32x32 register file: ALU/load arbitration, load formatting,
// and a pending-write scoreboard. Define WB_BYPASS_EN to forward Write_data to issue.
module reg_writeback_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rs1,
    input  logic [ADDR_W-1:0]        issue_rs2,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic                     issue_wr,
    output logic                     issue_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [2:0]               ld_funct3,
    input  logic [1:0]               ld_addr_lo,
    input  logic [XLEN-1:0]          ld_word,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        Rd,
    output logic [XLEN-1:0]          Write_data,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic                     fwd_rs1,
    output logic                     fwd_rs2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_next_s;
    logic [NREG-1:0]   clr_mask_s;
    logic [NREG-1:0]   set_mask_s;
    logic              ld_ready_s;
    logic              ld_fire_s;
    logic              accept_s;
    logic [ADDR_W-1:0] res_rd_s;
    logic [XLEN-1:0]   res_data_s;
    logic              set_en_s;
    logic              raw_s;
    logic              waw_s;
    logic              inflight_rs1_s;
    logic              inflight_rs2_s;
    logic              stall_fly_s;
    logic              issue_ready_s;
    logic              fwd_rs1_s;
    logic              fwd_rs2_s;

    // Shift the addressed byte/halfword down and extend it; reserved encodings behave as lw.
    function automatic logic [31:0] format_load(
        input logic [2:0]  funct3,
        input logic [1:0]  addr_lo,
        input logic [31:0] word
    );
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res_s;
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        half_s = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
            3'b001:  res_s = {{16{half_s[15]}}, half_s};
            3'b100:  res_s = {24'd0, byte_s};
            3'b101:  res_s = {16'd0, half_s};
            default: res_s = word;
        endcase
        return res_s;
    endfunction

    // Write-port arbitration: the ALU has no back-pressure, so it always wins.
    always_comb begin
        ld_ready_s = 1'b0;
        ld_fire_s  = 1'b0;
        accept_s   = 1'b0;
        res_rd_s   = {ADDR_W{1'b0}};
        res_data_s = {XLEN{1'b0}};
        if (reset) begin
            ld_ready_s = 1'b0;
        end else begin
            ld_ready_s = ~alu_valid;
            ld_fire_s  = ld_valid & ld_ready_s;
            accept_s   = alu_valid | ld_fire_s;
            if (alu_valid) begin
                res_rd_s   = alu_rd;
                res_data_s = alu_data;
            end else begin
                res_rd_s   = ld_rd;
                res_data_s = format_load(ld_funct3, ld_addr_lo, ld_word);
            end
        end
    end

    // Hazard detection and optional forwarding of the write currently on the port.
    always_comb begin
        raw_s          = busy_r[issue_rs1] | busy_r[issue_rs2];
        waw_s          = issue_wr & busy_r[issue_rd];
        inflight_rs1_s = RegWrite && (Rd != {ADDR_W{1'b0}}) && (Rd == issue_rs1);
        inflight_rs2_s = RegWrite && (Rd != {ADDR_W{1'b0}}) && (Rd == issue_rs2);
`ifdef WB_BYPASS_EN
        stall_fly_s    = 1'b0;
        fwd_rs1_s      = inflight_rs1_s & ~reset;
        fwd_rs2_s      = inflight_rs2_s & ~reset;
`else
        stall_fly_s    = inflight_rs1_s | inflight_rs2_s;
        fwd_rs1_s      = 1'b0;
        fwd_rs2_s      = 1'b0;
`endif
        issue_ready_s  = ~reset & ~raw_s & ~waw_s & ~stall_fly_s;
    end

    // Scoreboard update: a set on the same index as a clear takes precedence.
    always_comb begin
        set_en_s    = issue_valid & issue_ready_s & issue_wr & (issue_rd != {ADDR_W{1'b0}});
        clr_mask_s  = accept_s ? ({{(NREG-1){1'b0}}, 1'b1} << res_rd_s) : {NREG{1'b0}};
        set_mask_s  = set_en_s ? ({{(NREG-1){1'b0}}, 1'b1} << issue_rd) : {NREG{1'b0}};
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_next_s[0] = 1'b0;
    end

    // Registered write port and scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            Rd         <= {ADDR_W{1'b0}};
            Write_data <= {XLEN{1'b0}};
            busy_r     <= {NREG{1'b0}};
        end else begin
            RegWrite <= accept_s && (res_rd_s != {ADDR_W{1'b0}});
            if (accept_s) begin
                Rd         <= res_rd_s;
                Write_data <= res_data_s;
            end
            busy_r <= busy_next_s;
        end
    end

    assign issue_ready = issue_ready_s;
    assign ld_ready    = ld_ready_s;
    assign busy_vec    = busy_r;
    assign fwd_rs1     = fwd_rs1_s;
    assign fwd_rs2     = fwd_rs2_s;

endmodule
